narrow_32x16_tx: RTL and testbench

Narrowing transmitter for the datapath's 16-bit side channels. It accepts a 32-bit register value and emits it as 16-bit halfwords over a valid/ready link. Narrowing is the inverse of halfword sign extension, so the block checks whether the value survives the round trip and flags or saturates when it does not. It sits between the register-file read port and any 16-bit consumer, such as a halfword store path or an immediate re-encoder.

---
 rtl/narrow_32x16_tx.sv | 115 +++++++++++
 tb/tb_narrow_32x16_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/narrow_32x16_tx.sv
// Narrowing transmitter: accepts a 32-bit value and emits it as 16-bit beats
// (truncate, saturate or two-beat word split), flagging values that do not
// survive a halfword sign-extension round trip and counting those events.
module narrow_32x16_tx (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [1:0]  in_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic        out_ovf,
    input  logic        clr_count,
    output logic [15:0] ovf_count
);

    typedef enum logic [1:0] {StIdle, StSendLo, StSendHi} state_t;

    state_t      state_q, state_d;
    logic [15:0] data_q, data_d;
    logic [15:0] hi_q, hi_d;
    logic        last_q, last_d;
    logic        ovf_q, ovf_d;
    logic [15:0] count_q, count_d;

    logic        in_ovf;
    logic [15:0] sat_data;
    logic        out_hs;
    logic        accept;

    // Overflow test and saturated value for the incoming word
    always_comb begin
        in_ovf   = !((&in_data[31:15]) || !(|in_data[31:15]));
        sat_data = in_data[15:0];
        if (in_ovf) begin
            sat_data = in_data[31] ? 16'h8000 : 16'h7FFF;
        end
    end

    // Handshakes; in_ready opens combinationally on a final-beat handshake
    always_comb begin
        out_valid = (state_q != StIdle);
        out_hs    = out_valid && out_ready;
        in_ready  = (state_q == StIdle) || (out_hs && last_q);
        accept    = in_valid && in_ready;
    end

    // Next-state logic; the output beat is held in registers so it is stable under stall
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        hi_d    = hi_q;
        last_d  = last_q;
        ovf_d   = ovf_q;
        if (out_hs) begin
            if (last_q) begin
                state_d = StIdle;
            end else begin
                state_d = StSendHi;
                data_d  = hi_q;
                last_d  = 1'b1;
                ovf_d   = 1'b0;
            end
        end
        // A new accept only happens when idle or on a final beat, so it wins cleanly
        if (accept) begin
            state_d = StSendLo;
            hi_d    = in_data[31:16];
            last_d  = !in_mode[1];
            ovf_d   = in_mode[1] ? 1'b0 : in_ovf;
            data_d  = (in_mode == 2'b01) ? sat_data : in_data[15:0];
        end
    end

    // Saturating overflow counter; clear beats a coincident increment
    always_comb begin
        count_d = count_q;
        if (clr_count) begin
            count_d = 16'h0000;
        end else if (accept && !in_mode[1] && in_ovf && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            data_q  <= 16'h0000;
            hi_q    <= 16'h0000;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
            count_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            hi_q    <= hi_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

    // Output drive
    always_comb begin
        out_data  = data_q;
        out_last  = last_q;
        out_ovf   = ovf_q;
        ovf_count = count_q;
    end

endmodule

// File: tb/tb_narrow_32x16_tx.sv
// Self-checking bench for narrow_32x16_tx: directed cases plus random traffic
// checked against a transaction-level model (queue of expected beats).
module tb_narrow_32x16_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ovf;
    logic        clr_count;
    logic [15:0] ovf_count;

    narrow_32x16_tx dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ovf   (out_ovf),
        .clr_count (clr_count),
        .ovf_count (ovf_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        l;
        logic        o;
    } beat_t;

    beat_t       exp_q[$];
    int unsigned cnt_model;
    int unsigned pass_cnt = 0;
    int unsigned tot_cnt  = 0;

    logic        stall_prev = 1'b0;
    logic [15:0] prev_data;
    logic        prev_last;
    logic        prev_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tot_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference: a transaction becomes one or two beats; overflow is range loss of a signed value
    task automatic model_accept(input logic [31:0] data, input logic [1:0] mode, input logic clr);
        int    v;
        logic  ovf;
        beat_t b;
        v   = int'(data);
        ovf = (v < -32768) || (v > 32767);
        if (mode[1]) begin
            b.d = data[15:0];  b.l = 1'b0; b.o = 1'b0; exp_q.push_back(b);
            b.d = data[31:16]; b.l = 1'b1; b.o = 1'b0; exp_q.push_back(b);
        end else begin
            b.l = 1'b1;
            b.o = ovf;
            if (mode == 2'b01 && ovf) b.d = (v < 0) ? 16'h8000 : 16'h7FFF;
            else                      b.d = data[15:0];
            exp_q.push_back(b);
            if (ovf && !clr && cnt_model < 65535) cnt_model++;
        end
    endtask

    // One clock: check outputs mid-cycle, then advance model across the rising edge
    task automatic step();
        logic exp_ready;
        logic acc;
        logic hs;
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        exp_ready = (exp_q.size() == 0) || (exp_q[0].l && out_ready);
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        if (exp_q.size() > 0 && out_valid) begin
            chk("out_data", 32'(out_data), 32'(exp_q[0].d));
            chk("out_last", 32'(out_last), 32'(exp_q[0].l));
            chk("out_ovf", 32'(out_ovf), 32'(exp_q[0].o));
            if (stall_prev) begin
                chk("stable_data", 32'(out_data), 32'(prev_data));
                chk("stable_last", 32'(out_last), 32'(prev_last));
                chk("stable_ovf", 32'(out_ovf), 32'(prev_ovf));
            end
        end
        chk("ovf_count", 32'(ovf_count), cnt_model);
        stall_prev = (exp_q.size() > 0) && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        prev_ovf   = out_ovf;
        acc = in_valid && exp_ready;
        hs  = (exp_q.size() > 0) && out_ready;
        @(posedge clk);
        if (hs) void'(exp_q.pop_front());
        if (clr_count) cnt_model = 0;
        if (acc) model_accept(in_data, in_mode, clr_count);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [1:0] m);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b1;  // must be ignored while in reset
        in_data   = 32'h0001_0000;
        in_mode   = 2'b00;
        out_ready = 1'b1;
        clr_count = 1'b0;
        cnt_model = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_last", 32'(out_last), 32'h0);
        chk("rst_out_ovf", 32'(out_ovf), 32'h0);
        chk("rst_ovf_count", 32'(ovf_count), 32'h0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        step();

        // Truncate
        send(32'hFFFF_8001, 2'b00);
        step();
        send(32'h0001_2345, 2'b00);
        step();

        // Saturate
        send(32'h0001_0000, 2'b01);
        step();
        send(32'hFFFE_0000, 2'b01);
        step();
        send(32'h0000_7FFF, 2'b01);
        step();

        // Word split with 3-cycle stalls per beat; next input waits meanwhile
        send(32'hDEAD_BEEF, 2'b10);
        in_valid  = 1'b1;
        in_data   = 32'h1234_5678;
        in_mode   = 2'b11;
        out_ready = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();

        // Back-to-back single-beat transactions
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            in_mode  = 2'b00;
            step();
        end
        in_valid = 1'b0;
        repeat (2) step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_mode   = 2'($urandom_range(0, 3));
            in_data   = ($urandom_range(0, 1) == 1) ? $urandom
                                                    : 32'(int'($urandom_range(0, 65535)) - 32768);
            clr_count = ($urandom_range(0, 49) == 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr_count = 1'b0;
        repeat (3) step();

        // Reset in the middle of a word split, after beat 1
        send(32'h0002_0000, 2'b00);
        step();
        send(32'hDEAD_BEEF, 2'b10);
        step();
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_out_data", 32'(out_data), 32'h0);
        chk("midrst_ovf_count", 32'(ovf_count), 32'h0);
        exp_q.delete();
        cnt_model  = 0;
        stall_prev = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) step();

        // Counter saturation then clear-priority
        in_valid  = 1'b1;
        in_mode   = 2'b00;
        out_ready = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            in_data = {15'($urandom), 1'b1, 16'($urandom)};
            step();
        end
        in_data = 32'h8000_0000;
        step();
        chk("count_saturated", 32'(ovf_count), 32'hFFFF);
        clr_count = 1'b1;
        in_data   = 32'h0004_0000;
        step();
        clr_count = 1'b0;
        in_valid  = 1'b0;
        repeat (2) step();
        chk("count_cleared", 32'(ovf_count), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
